// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache: direct-mapped, read-only instruction cache between the fetch
// stage and the memory controller.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-low
//   rdy            global ready; low freezes every piece of sequential state
//   pc_in          fetch address (bits [1:0] ignored)
//   inst_get_ready hit: inst_out holds the word for pc_in this cycle
//   inst_out       instruction word, 0 when not a hit
//   mem_req_valid  word-read request to the memory controller
//   mem_req_addr   word-aligned request address
//   mem_resp_valid one-cycle pulse, mem_resp_data valid for the open request
//   mem_resp_data  returned word
//
// Handshake: mem_req_valid/mem_req_addr are held stable until a
// mem_resp_valid pulse arrives in a cycle with rdy high; that pulse retires
// the request. Only one request is ever outstanding. A pulse in a cycle with
// rdy low is dropped and the same word is requested again.
//
// The lookup is purely combinational and independent of rdy and FSM state.
// A miss in IDLE starts a refill of the whole line, one word per response.
// The line being refilled has its valid bit cleared, so it never hits while
// only partially written.
// -----------------------------------------------------------------------------
module inst_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_in,
  output logic        inst_get_ready,
  output logic [31:0] inst_out,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Address split of the fetch PC
  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [TAG_BITS-1:0]    pc_tag;
  logic [1:0]             unused_pc_lsbs;

  assign pc_offset      = pc_in[OFFSET_BITS+1:2];
  assign pc_index       = pc_in[TAG_LSB-1:OFFSET_BITS+2];
  assign pc_tag         = pc_in[31:TAG_LSB];
  assign unused_pc_lsbs = pc_in[1:0];

  // Line storage; data is flattened as {index, word offset}
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  // Refill bookkeeping
  logic [INDEX_BITS-1:0]  ref_index;
  logic [TAG_BITS-1:0]    ref_tag;
  logic [OFFSET_BITS-1:0] counter;

  logic hit;
  logic start_refill;
  logic take_word;
  logic last_word;

  // Lookup
  assign hit            = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign inst_get_ready = hit;
  assign inst_out       = hit ? data_mem[{pc_index, pc_offset}] : 32'h0;

  // Next-state and control strobes; rdy gating is applied at the registers
  always_comb begin
    state_next   = state;
    start_refill = 1'b0;
    take_word    = 1'b0;
    last_word    = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          start_refill = 1'b1;
          state_next   = REFILL;
        end
      end
      REFILL: begin
        if (mem_resp_valid) begin
          take_word = 1'b1;
          if (counter == '1) begin
            last_word  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, request interface, refill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= '0;
      counter       <= '0;
      ref_index     <= '0;
      ref_tag       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
    end else if (rdy) begin
      state <= state_next;
      if (start_refill) begin
        ref_index       <= pc_index;
        ref_tag         <= pc_tag;
        valid[pc_index] <= 1'b0;
        counter         <= '0;
        mem_req_valid   <= 1'b1;
        mem_req_addr    <= {pc_in[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
      end
      if (take_word) begin
        if (last_word) begin
          valid[ref_index] <= 1'b1;
          mem_req_valid    <= 1'b0;
        end else begin
          // Counter never passes the last word, so +4 stays inside the line
          counter      <= counter + 1'b1;
          mem_req_addr <= mem_req_addr + 32'd4;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (rdy && take_word) begin
      data_mem[{ref_index, counter}] <= mem_resp_data;
      if (last_word) begin
        tag_mem[ref_index] <= ref_tag;
      end
    end
  end

endmodule
